// File: rtl/data_bus_port_pkg.sv
// Shared sizing for the wired-OR data bus: the arbiter and every port import
// these so they agree on word width and transmit buffering.
package data_bus_port_pkg;

  localparam int BUS_DATA_WIDTH      = 8;
  localparam int DATA_BUS_PORT_DEPTH = 4;

  // Occupancy needs one extra bit so a completely full FIFO is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DATA_BUS_PORT_CNT_W = count_width(DATA_BUS_PORT_DEPTH);

endpackage

// File: rtl/data_bus_fifo.sv
// Small synchronous FIFO with an occupancy counter; full/empty come from the
// count rather than from pointer comparison.
module data_bus_fifo
  import data_bus_port_pkg::*;
#(
  parameter int WIDTH = BUS_DATA_WIDTH,
  parameter int DEPTH = DATA_BUS_PORT_DEPTH,
  parameter int CNT_W = DATA_BUS_PORT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/data_bus_port.sv
// Module-side endpoint of a wired-OR data bus segment: queues outgoing words,
// drives them only while granted, and captures the combined bus on rx_en.
module data_bus_port
  import data_bus_port_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int DEPTH      = DATA_BUS_PORT_DEPTH,
  parameter int CNT_W      = DATA_BUS_PORT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [CNT_W-1:0]      tx_count,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic [DATA_WIDTH-1:0] bus_drive,
  input  logic [DATA_WIDTH-1:0] bus_sample,
  input  logic                  rx_en,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  err_gnt_empty
);

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  assign tx_ready = !fifo_full;
  assign push     = tx_valid && tx_ready;
  assign pop      = bus_gnt && !fifo_empty;
  assign bus_req  = !fifo_empty;

  // Anything but zero outside an owned cycle would corrupt the OR-combined bus.
  assign bus_drive = pop ? fifo_head : '0;

  data_bus_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (tx_data),
    .head    (fifo_head),
    .count   (tx_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (rx_en) rx_data <= bus_sample;
      rx_valid <= rx_en;
    end
  end

  // A grant with nothing queued points at an arbiter fault; latch it for software.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_gnt_empty <= 1'b0;
    end else if (bus_gnt && fifo_empty) begin
      err_gnt_empty <= 1'b1;
    end
  end

endmodule
